mul_seq32: RTL and testbench

MUL_SEQ32 -- requirements
Module: mul_seq32

---
 rtl/mul_seq32_if.sv | 22 ++
 rtl/mul_seq32.sv | 118 +++++++++++
 tb/tb_mul_seq32.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/mul_seq32_if.sv
// Request/response bundle for the sequential 32x32 multiplier.
// The master issues operands with a start pulse; the slave reports
// progress (busy), completion (done) and the held 64-bit product.
interface mul_seq32_if;
    logic        start;
    logic        is_signed;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [63:0] product;

    modport master (
        output start, is_signed, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, is_signed, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/mul_seq32.sv
// Sequential shift-and-add multiplier, 32x32 -> 64, signed or unsigned.
// Signed operands are reduced to magnitudes on accept. The magnitudes are
// multiplied over 32 CALC cycles, and the sign is applied in a single FIX
// cycle. The product register only updates on the FIX->DONE edge, so the
// last result is held across any operation that follows.
module mul_seq32 (
    input  logic         clk,
    input  logic         rst,
    mul_seq32_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] mcand;      // multiplicand magnitude
    logic [31:0] hi;         // upper accumulator; the carry lives only in add_sum
    logic [31:0] lo;         // lower accumulator, starts as multiplier magnitude
    logic [4:0]  cnt;        // CALC iteration index, 0..31
    logic        neg;        // result must be negated in FIX
    logic        busy_q;
    logic        done_q;
    logic [63:0] product_q;

    logic        accept;
    logic [32:0] add_sum;
    logic [32:0] step_sum;
    logic [63:0] mag;
    logic [63:0] fixed;
    logic [31:0] abs_a;
    logic [31:0] abs_b;

    // Two's-complement magnitude. 32'h8000_0000 maps to itself, which is
    // exactly 2^31 when read as unsigned, so no special case is needed.
    function automatic logic [31:0] abs32(input logic [31:0] x);
        return x[31] ? (~x + 32'd1) : x;
    endfunction

    // A new request is only taken when no operation is in flight.
    assign accept = bus.start && ((state == IDLE) || (state == DONE));

    assign abs_a = abs32(bus.a);
    assign abs_b = abs32(bus.b);

    // One shift-and-add step: conditionally add the multiplicand into the
    // upper half (keeping the carry-out), then everything shifts right.
    always_comb begin
        add_sum  = {1'b0, hi} + {1'b0, mcand};
        step_sum = lo[0] ? add_sum : {1'b0, hi};
    end

    // Sign correction of the unsigned magnitude product.
    always_comb begin
        mag   = {hi, lo};
        fixed = neg ? (~mag + 64'd1) : mag;
    end

    // Control FSM and datapath, with busy/done registered alongside the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            mcand     <= 32'h0;
            hi        <= 32'h0;
            lo        <= 32'h0;
            cnt       <= 5'd0;
            neg       <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= 64'h0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (accept) begin
                        mcand  <= bus.is_signed ? abs_a : bus.a;
                        lo     <= bus.is_signed ? abs_b : bus.b;
                        neg    <= bus.is_signed & (bus.a[31] ^ bus.b[31]);
                        hi     <= 32'h0;
                        cnt    <= 5'd0;
                        busy_q <= 1'b1;
                        state  <= CALC;
                    end else begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                CALC: begin
                    hi  <= step_sum[32:1];
                    lo  <= {step_sum[0], lo[31:1]};
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    product_q <= fixed;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state     <= DONE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

endmodule

// File: tb/tb_mul_seq32.sv
// Scoreboard bench for mul_seq32: the stimulus side pushes the expected product
// and the issue cycle, and the monitor pops them on every done pulse to check the
// value and the 34-cycle latency.
module tb_mul_seq32;

    typedef struct {
        logic [63:0] exp;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst;
    mul_seq32_if bus ();

    mul_seq32 u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    logic prev_done = 1'b0;
    exp_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: protocol invariants plus scoreboard pop on each done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.busy && bus.done) begin
                checks++; errors++;
                $display("FAIL busy_and_done: both high at cycle %0d", cyc);
            end
            if (bus.done && prev_done) begin
                checks++; errors++;
                $display("FAIL done_width: done high two cycles at cycle %0d", cyc);
            end
            if (bus.done) begin
                done_cnt++;
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done: product %h at cycle %0d", bus.product, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("product", bus.product, e.exp);
                    chk("latency", 64'(cyc - e.cyc), 64'd34);
                end
            end
            prev_done = bus.done;
        end else begin
            prev_done = 1'b0;
        end
    end

    // Called at a negedge with the block able to accept. Drives one start
    // cycle and returns at the following negedge.
    task automatic issue(input logic [31:0] ia, input logic [31:0] ib,
                         input logic is, input logic [63:0] exp);
        exp_t e;
        bus.start     = 1'b1;
        bus.a         = ia;
        bus.b         = ib;
        bus.is_signed = is;
        e.exp = exp;
        e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
    endtask

    task automatic drain();
        int guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d results outstanding", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done();
        int guard = 0;
        while (!bus.done && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.done) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done pulse seen");
        end
    endtask

    task automatic run(input logic [31:0] ia, input logic [31:0] ib,
                       input logic is, input logic [63:0] exp);
        issue(ia, ib, is, exp);
        drain();
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        longint      sa, sb_v;
        logic [63:0] rexp;
        int          dc;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.is_signed = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_done", 64'(bus.done), 64'd0);
        chk("rst_product", bus.product, 64'h0);
        rst = 1'b0;

        // Issued on the very negedge reset drops: accepted on the first edge.
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001);
        run(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000);
        run(32'hFFFF_FFFF, 32'd7,         1'b1, 64'hFFFF_FFFF_FFFF_FFF9);
        run(32'h8000_0000, 32'd2,         1'b0, 64'h0000_0001_0000_0000);
        run(32'h8000_0000, 32'd1,         1'b1, 64'hFFFF_FFFF_8000_0000);
        run(32'hFFFF_FFFD, 32'hFFFF_FFFB, 1'b1, 64'd15);
        run(32'h7FFF_FFFF, 32'h8000_0000, 1'b1, 64'hC000_0000_8000_0000);
        run(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'd1);
        run(32'h0001_0000, 32'h0001_0000, 1'b0, 64'h0000_0001_0000_0000);
        run(32'h1234_5678, 32'd1,         1'b0, 64'h0000_0000_1234_5678);

        // Start during CALC is ignored; changed operands do not disturb the op.
        issue(32'd3, 32'd5, 1'b0, 64'd15);
        repeat (8) @(negedge clk);
        bus.start = 1'b1;
        bus.a = 32'd9;
        bus.b = 32'd9;
        bus.is_signed = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        dc = done_cnt;
        drain();
        repeat (40) @(negedge clk);
        chk("ignore_single_done", 64'(done_cnt - dc), 64'd1);

        // Back-to-back: second start in the DONE cycle; first result held.
        issue(32'hFFFF_FFFF, 32'd2, 1'b0, 64'h0000_0001_FFFF_FFFE);
        wait_done();
        issue(32'd0, 32'h1234_5678, 1'b0, 64'h0);
        repeat (10) @(negedge clk);
        chk("held_product", bus.product, 64'h0000_0001_FFFF_FFFE);
        chk("b2b_busy", 64'(bus.busy), 64'd1);
        drain();

        // Reset mid-operation aborts with no done pulse.
        run(32'd6, 32'd7, 1'b0, 64'd42);
        issue(32'd5, 32'd6, 1'b0, 64'd30);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        #1;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_product", bus.product, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        dc = done_cnt;
        repeat (45) @(negedge clk);
        chk("abort_no_done", 64'(done_cnt - dc), 64'd0);
        chk("abort_product_held", bus.product, 64'h0);

        // Random operations against an arithmetic reference model.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            if (i % 10 == 0) ra = 32'h8000_0000;
            if (i % 15 == 0) rb = 32'hFFFF_FFFF;
            if (rs) begin
                sa   = longint'($signed(ra));
                sb_v = longint'($signed(rb));
                rexp = 64'(sa * sb_v);
            end else begin
                rexp = {32'h0, ra} * {32'h0, rb};
            end
            run(ra, rb, rs, rexp);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
